// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared types and helpers for the rate-1/2, K=3 Viterbi
//               decoder: default soft width, symbol hypotheses and the
//               per-bit branch distance function.
// Revision    : 1.0 - initial soft-decision release
// ============================================================================
package viterbi_pkg;

    // Default number of bits per received soft value.
    localparam int c_SOFT_W_DEFAULT = 3;

    // Widest soft value the distance helper supports.
    localparam int c_MAX_SOFT_W = 8;

    typedef logic [c_MAX_SOFT_W-1:0] dist_t;

    // Hypothesised transmitted symbol {bit1, bit0}.
    typedef enum logic [1:0] {
        SYM00 = 2'b00,
        SYM01 = 2'b01,
        SYM10 = 2'b10,
        SYM11 = 2'b11
    } sym_t;

    // Distance of received value r (w significant bits) from hypothesis b.
    // Soft: r for b=0, full-scale minus r for b=1.
    // Hard: only the MSB counts, giving either 0 or half-scale.
    // Erased bits carry no information and cost nothing.
    function automatic dist_t bit_dist(
        input dist_t r,
        input int    w,
        input logic  b,
        input logic  hard,
        input logic  erased
    );
        dist_t half;
        dist_t maxv;
        logic  msb;
        dist_t res;
        half = dist_t'(1) << (w - 1);
        maxv = (half << 1) - dist_t'(1);
        msb  = |(r & half);
        if (erased) begin
            res = '0;
        end else if (hard) begin
            res = (msb ^ b) ? half : '0;
        end else begin
            res = b ? (maxv - r) : r;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmc_soft_if.sv
`default_nettype none
// ============================================================================
// Module      : bmc_soft_if
// Description : Received-symbol input stream and branch-metric output stream
//               of the soft branch-metric unit, both valid/ready.
// Revision    : 1.0 - initial soft-decision release
// ============================================================================
interface bmc_soft_if
    import viterbi_pkg::*;
#(
    parameter int SOFT_W = c_SOFT_W_DEFAULT,
    parameter int IDX_W  = 10
);
    localparam int MW = SOFT_W + 1;

    // Input beat
    logic              hard_mode;
    logic              in_valid;
    logic              in_ready;
    logic [SOFT_W-1:0] rx_soft1;
    logic [SOFT_W-1:0] rx_soft0;
    logic [1:0]        erase;
    logic              in_last;

    // Output metrics
    logic              out_valid;
    logic              out_ready;
    logic [MW-1:0]     bm00;
    logic [MW-1:0]     bm01;
    logic [MW-1:0]     bm10;
    logic [MW-1:0]     bm11;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    // Branch-metric unit side
    modport slave (
        input  hard_mode, in_valid, rx_soft1, rx_soft0, erase, in_last,
        input  out_ready,
        output in_ready, out_valid, bm00, bm01, bm10, bm11, out_idx, out_last
    );

    // Symbol source / ACS side
    modport master (
        output hard_mode, in_valid, rx_soft1, rx_soft0, erase, in_last,
        output out_ready,
        input  in_ready, out_valid, bm00, bm01, bm10, bm11, out_idx, out_last
    );

endinterface
`default_nettype wire

// File: rtl/bmc_dist.sv
`default_nettype none
// ============================================================================
// Module      : bmc_dist
// Description : Combinational distance of one received coded bit from both
//               hypotheses (b=0 and b=1).
// Revision    : 1.0 - initial soft-decision release
// ============================================================================
module bmc_dist
    import viterbi_pkg::*;
#(
    parameter int SOFT_W = c_SOFT_W_DEFAULT
) (
    input  wire logic [SOFT_W-1:0] i_r,
    input  wire logic              i_hard,
    input  wire logic              i_erased,
    output logic      [SOFT_W-1:0] o_d0,
    output logic      [SOFT_W-1:0] o_d1
);

    dist_t w_r;
    dist_t w_d0_full;
    dist_t w_d1_full;

    assign w_r       = dist_t'(i_r);
    assign w_d0_full = bit_dist(w_r, SOFT_W, 1'b0, i_hard, i_erased);
    assign w_d1_full = bit_dist(w_r, SOFT_W, 1'b1, i_hard, i_erased);

    assign o_d0 = w_d0_full[SOFT_W-1:0];
    assign o_d1 = w_d1_full[SOFT_W-1:0];

    // Distances never exceed SOFT_W bits; the helper's upper bits are zero.
    generate
        if (SOFT_W < c_MAX_SOFT_W) begin : g_trim
            logic w_unused_hi;
            assign w_unused_hi = ^{w_d0_full[c_MAX_SOFT_W-1:SOFT_W],
                                   w_d1_full[c_MAX_SOFT_W-1:SOFT_W]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bmc_soft.sv
`default_nettype none
// ============================================================================
// Module      : bmc_soft
// Description : Soft/hard/punctured branch-metric unit for the rate-1/2,
//               K=3 Viterbi decoder. Two-stage valid/ready pipeline:
//               S1 holds per-bit distances, S2 holds the four metric sums.
//               Tags each symbol with its in-frame index.
// Revision    : 1.0 - initial soft-decision release
// ============================================================================
module bmc_soft
    import viterbi_pkg::*;
#(
    parameter int SOFT_W = c_SOFT_W_DEFAULT,
    parameter int IDX_W  = 10
) (
    input wire logic clk,
    input wire logic rst,
    bmc_soft_if.slave bus
);

    localparam int MW = SOFT_W + 1;

    // Combinational per-bit distances for the incoming beat
    logic [SOFT_W-1:0] w_d1_b0;
    logic [SOFT_W-1:0] w_d1_b1;
    logic [SOFT_W-1:0] w_d0_b0;
    logic [SOFT_W-1:0] w_d0_b1;

    // Handshake
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    // Stage 1: distances indexed by hypothesis bit value
    logic              r_s1_valid;
    logic [SOFT_W-1:0] r_s1_d1 [2];
    logic [SOFT_W-1:0] r_s1_d0 [2];
    logic [IDX_W-1:0]  r_s1_idx;
    logic              r_s1_last;

    // Stage 2: metrics indexed by hypothesis symbol
    logic              r_s2_valid;
    logic [MW-1:0]     r_s2_bm [4];
    logic [IDX_W-1:0]  r_s2_idx;
    logic              r_s2_last;

    logic [MW-1:0]     w_sum [4];
    logic [IDX_W-1:0]  r_sym_cnt;

    bmc_dist #(.SOFT_W(SOFT_W)) u_dist1 (
        .i_r      (bus.rx_soft1),
        .i_hard   (bus.hard_mode),
        .i_erased (bus.erase[1]),
        .o_d0     (w_d1_b0),
        .o_d1     (w_d1_b1)
    );

    bmc_dist #(.SOFT_W(SOFT_W)) u_dist0 (
        .i_r      (bus.rx_soft0),
        .i_hard   (bus.hard_mode),
        .i_erased (bus.erase[0]),
        .o_d0     (w_d0_b0),
        .o_d1     (w_d0_b1)
    );

    // A stage may load when it is empty or its content leaves this cycle.
    assign w_s2_adv = ~r_s2_valid | bus.out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign w_accept = bus.in_valid & w_s1_adv;

    // Metric for hypothesis {H1,H0} is d(rx1,H1) + d(rx0,H0).
    always_comb begin
        w_sum[SYM00] = MW'(r_s1_d1[0]) + MW'(r_s1_d0[0]);
        w_sum[SYM01] = MW'(r_s1_d1[0]) + MW'(r_s1_d0[1]);
        w_sum[SYM10] = MW'(r_s1_d1[1]) + MW'(r_s1_d0[0]);
        w_sum[SYM11] = MW'(r_s1_d1[1]) + MW'(r_s1_d0[1]);
    end

    // Stage 1: capture distances and frame tags of an accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_d1    <= '{default: '0};
            r_s1_d0    <= '{default: '0};
            r_s1_idx   <= '0;
            r_s1_last  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_d1[0] <= w_d1_b0;
                r_s1_d1[1] <= w_d1_b1;
                r_s1_d0[0] <= w_d0_b0;
                r_s1_d0[1] <= w_d0_b1;
                r_s1_idx   <= r_sym_cnt;
                r_s1_last  <= bus.in_last;
            end
        end
    end

    // Stage 2: register the four sums when the output slot frees up
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_bm    <= '{default: '0};
            r_s2_idx   <= '0;
            r_s2_last  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_bm   <= w_sum;
                r_s2_idx  <= r_s1_idx;
                r_s2_last <= r_s1_last;
            end
        end
    end

    // Symbol index: advance per accepted beat, restart after the frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sym_cnt <= '0;
        end else if (w_accept) begin
            r_sym_cnt <= bus.in_last ? '0 : r_sym_cnt + IDX_W'(1);
        end
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_valid;
    assign bus.bm00      = r_s2_bm[SYM00];
    assign bus.bm01      = r_s2_bm[SYM01];
    assign bus.bm10      = r_s2_bm[SYM10];
    assign bus.bm11      = r_s2_bm[SYM11];
    assign bus.out_idx   = r_s2_idx;
    assign bus.out_last  = r_s2_last;

endmodule
`default_nettype wire

// File: tb/tb_bmc_soft.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmc_soft
// Description : Self-checking bench for bmc_soft. Instance A (SOFT_W=3,
//               IDX_W=10) runs directed and random traffic against a
//               queue-based reference model; instance B (SOFT_W=1, IDX_W=2)
//               covers the legacy hard-decision metrics and index wrap.
// Revision    : 1.0 - initial soft-decision release
// ============================================================================
module tb_bmc_soft;

    localparam int SW  = 3;
    localparam int IW  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bmc_soft_if #(.SOFT_W(SW), .IDX_W(IW)) bus_a ();
    bmc_soft_if #(.SOFT_W(1),  .IDX_W(2))  bus_b ();

    bmc_soft #(.SOFT_W(SW), .IDX_W(IW)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    bmc_soft #(.SOFT_W(1),  .IDX_W(2))  u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference distance straight from the bit-distance rules.
    function automatic int ref_dist(input int r, input int b, input bit hard,
                                    input bit er, input int w);
        int full;
        int msb;
        full = (1 << w) - 1;
        msb  = (r >> (w - 1)) & 1;
        if (er)   return 0;
        if (hard) return (msb != b) ? (1 << (w - 1)) : 0;
        return (b != 0) ? (full - r) : r;
    endfunction

    typedef struct {
        int bm00;
        int bm01;
        int bm10;
        int bm11;
        int idx;
        int last;
        int acc;
    } exp_t;

    exp_t q [$];
    int   cyc  = 0;
    int   mcnt = 0;

    // Reference model for instance A: beats in flight are a queue; a beat is
    // visible at the output from two cycles after its acceptance onward.
    always @(negedge clk) begin
        bit   exp_valid;
        exp_t e;
        int   r1, r0;
        bit   h, e1, e0;
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
            chk_eq("in_ready", int'(bus_a.in_ready),
                   int'(!(q.size() == 2 && !bus_a.out_ready)));
            chk_eq("out_valid", int'(bus_a.out_valid), int'(exp_valid));
            if (exp_valid) begin
                chk_eq("bm00", int'(bus_a.bm00), q[0].bm00);
                chk_eq("bm01", int'(bus_a.bm01), q[0].bm01);
                chk_eq("bm10", int'(bus_a.bm10), q[0].bm10);
                chk_eq("bm11", int'(bus_a.bm11), q[0].bm11);
                chk_eq("out_idx", int'(bus_a.out_idx), q[0].idx);
                chk_eq("out_last", int'(bus_a.out_last), q[0].last);
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                r1 = int'(bus_a.rx_soft1);
                r0 = int'(bus_a.rx_soft0);
                h  = bus_a.hard_mode;
                e1 = bus_a.erase[1];
                e0 = bus_a.erase[0];
                e.bm00 = ref_dist(r1, 0, h, e1, SW) + ref_dist(r0, 0, h, e0, SW);
                e.bm01 = ref_dist(r1, 0, h, e1, SW) + ref_dist(r0, 1, h, e0, SW);
                e.bm10 = ref_dist(r1, 1, h, e1, SW) + ref_dist(r0, 0, h, e0, SW);
                e.bm11 = ref_dist(r1, 1, h, e1, SW) + ref_dist(r0, 1, h, e0, SW);
                e.idx  = mcnt;
                e.last = int'(bus_a.in_last);
                e.acc  = cyc;
                q.push_back(e);
                mcnt = bus_a.in_last ? 0 : (mcnt + 1) % (1 << IW);
            end
            if (exp_valid && bus_a.out_ready) q.pop_front();
        end
        cyc++;
    end

    // Instance B: legacy 1-bit hard decision, IDX_W=2 wrap, no frame end.
    int b_r1 [5] = '{0, 0, 1, 1, 1};
    int b_r0 [5] = '{0, 1, 0, 1, 1};
    int b_seen = 0;

    initial begin
        bus_b.hard_mode = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.rx_soft1  = 1'b0;
        bus_b.rx_soft0  = 1'b0;
        bus_b.erase     = 2'b00;
        bus_b.in_last   = 1'b0;
        bus_b.out_ready = 1'b1;
        wait (rst == 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus_b.in_valid = 1'b1;
            bus_b.rx_soft1 = b_r1[k][0];
            bus_b.rx_soft0 = b_r0[k][0];
            @(posedge clk); #1;
        end
        bus_b.in_valid = 1'b0;
    end

    always @(negedge clk) begin
        int p;
        if (!rst && bus_b.out_valid) begin
            if (b_seen < 5) begin
                p = b_r1[b_seen] + b_r0[b_seen];
                chk_eq("b_bm00", int'(bus_b.bm00), p);
                chk_eq("b_bm01", int'(bus_b.bm01), b_r1[b_seen] + 1 - b_r0[b_seen]);
                chk_eq("b_bm10", int'(bus_b.bm10), 1 - b_r1[b_seen] + b_r0[b_seen]);
                chk_eq("b_bm11", int'(bus_b.bm11), 2 - p);
                chk_eq("b_idx",  int'(bus_b.out_idx), b_seen % 4);
                chk_eq("b_last", int'(bus_b.out_last), 0);
            end
            b_seen++;
        end
    end

    // Present one beat with out_ready high, then check it two cycles later.
    task automatic dir_beat(input bit h, input int r1, input int r0, input int er,
                            input bit last, input int e00, input int e01,
                            input int e10, input int e11, input int eidx,
                            input bit elast);
        bus_a.in_valid  = 1'b1;
        bus_a.hard_mode = h;
        bus_a.rx_soft1  = SW'(r1);
        bus_a.rx_soft0  = SW'(r0);
        bus_a.erase     = 2'(er);
        bus_a.in_last   = last;
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        @(posedge clk); #1;
        chk_eq("dir_valid", int'(bus_a.out_valid), 1);
        chk_eq("dir_bm00", int'(bus_a.bm00), e00);
        chk_eq("dir_bm01", int'(bus_a.bm01), e01);
        chk_eq("dir_bm10", int'(bus_a.bm10), e10);
        chk_eq("dir_bm11", int'(bus_a.bm11), e11);
        chk_eq("dir_idx",  int'(bus_a.out_idx), eidx);
        chk_eq("dir_last", int'(bus_a.out_last), int'(elast));
    endtask

    task automatic rand_fields(input bit allow_last);
        bus_a.hard_mode = 1'($urandom_range(0, 1));
        bus_a.rx_soft1  = SW'($urandom_range(0, 7));
        bus_a.rx_soft0  = SW'($urandom_range(0, 7));
        bus_a.erase     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        bus_a.in_last   = allow_last ? ($urandom_range(0, 7) == 0) : 1'b0;
    endtask

    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int sent;
        bus_a.hard_mode = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.rx_soft1  = '0;
        bus_a.rx_soft0  = '0;
        bus_a.erase     = 2'b00;
        bus_a.in_last   = 1'b0;
        bus_a.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // State straight after reset
        chk_eq("rst_out_valid", int'(bus_a.out_valid), 0);
        chk_eq("rst_in_ready",  int'(bus_a.in_ready), 1);
        chk_eq("rst_bm00", int'(bus_a.bm00), 0);
        chk_eq("rst_bm01", int'(bus_a.bm01), 0);
        chk_eq("rst_bm10", int'(bus_a.bm10), 0);
        chk_eq("rst_bm11", int'(bus_a.bm11), 0);
        chk_eq("rst_idx",  int'(bus_a.out_idx), 0);
        chk_eq("rst_last", int'(bus_a.out_last), 0);

        // Directed metric cases; frame of three then two more beats
        dir_beat(1'b0, 7, 0, 0, 1'b0, 7, 14, 0, 7, 0, 1'b0);
        dir_beat(1'b1, 4, 3, 0, 1'b0, 4, 8, 0, 4, 1, 1'b0);
        dir_beat(1'b0, 5, 6, 1, 1'b1, 5, 5, 2, 2, 2, 1'b1);
        dir_beat(1'b0, 5, 6, 3, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        dir_beat(1'b0, 2, 5, 0, 1'b0, 7, 4, 10, 7, 1, 1'b0);

        // Six back-to-back beats under a toggling out_ready
        sent = 0;
        rand_fields(1'b0);
        for (int c = 0; c < 16; c++) begin
            bus_a.out_ready = (c < 12) ? pat[c % 6] : 1'b1;
            bus_a.in_valid  = (sent < 6);
            @(negedge clk);
            if (bus_a.in_valid && bus_a.in_ready) sent++;
            @(posedge clk); #1;
            if (bus_a.in_valid && sent < 6) rand_fields(1'b0);
        end
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        chk_eq("stall_sent", sent, 6);
        repeat (3) @(posedge clk);
        #1 chk_eq("stall_drain", q.size(), 0);

        // Reset with two beats stalled in the pipeline
        bus_a.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rand_fields(1'b0);
            bus_a.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus_a.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_eq("midrst_out_valid", int'(bus_a.out_valid), 0);
        chk_eq("midrst_in_ready",  int'(bus_a.in_ready), 1);
        dir_beat(1'b0, 3, 4, 0, 1'b0, 7, 6, 8, 7, 0, 1'b0);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 399) == 0);
            bus_a.in_valid  = ($urandom_range(0, 3) != 0);
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            rand_fields(1'b1);
            @(posedge clk); #1;
        end
        rst             = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_eq("final_drain", q.size(), 0);
        chk_eq("b_count", b_seen, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
